vec_op_sequencer: RTL and testbench
===================================

VEC_OP_SEQUENCER -- requirements
Module: vec_op_sequencer

Interface
REQ-001 The block SHALL provide parameter ALU_LAT, default 2: number of cycles an ALU op (op 10/11) is held on the register file, legal range 1..15.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 4: instruction queue entries, power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 instr_valid  in  1  upstream instruction offered.
REQ-006 instr_ready  out  1  queue can accept an instruction this cycle.
REQ-007 instr_op  in  2  00 write, 01 read, 10/11 ALU.
REQ-008 instr_raddr  in  2  read register index.
REQ-009 instr_waddr  in  2  write register index.
REQ-010 instr_wdata  in  512  write payload.
REQ-011 rf_op_code  out  2  op driven to the register file.
REQ-012 rf_read_addr  out  2  register file read index.
REQ-013 rf_write_addr  out  2  register file write index.
REQ-014 rf_write_data  out  512  register file write payload.
REQ-015 rf_read_data  in  512  register file registered read output.
REQ-016 rsp_valid  out  1  read response available.
REQ-017 rsp_data  out  512  read response payload.
REQ-018 rsp_ready  in  1  downstream accepts the response.
REQ-019 busy  out  1  queue non-empty or FSM not IDLE.

Function
REQ-020 The queue SHALL be a FIFO of FIFO_DEPTH entries {op, raddr, waddr, wdata}; a push occurs when instr_valid && instr_ready.
REQ-021 instr_ready SHALL equal !full and SHALL NOT depend on a same-cycle pop; at full, the offered instruction is held off.
REQ-022 An entry pushed into an empty queue SHALL be poppable no earlier than the following cycle, with no bypass.
REQ-023 The FSM SHALL have states IDLE, EXEC, CAPT, RSP.
REQ-024 IDLE: if the queue is non-empty, pop the head into the current-instruction register, clear the cycle counter, and go to EXEC; otherwise stay in IDLE.
REQ-025 In IDLE, CAPT, RSP and reset, rf_op_code SHALL be 01 (harmless read) with rf_read_addr 0, rf_write_addr 0 and rf_write_data 0.
REQ-026 EXEC with op 00: drive rf_op_code 00 plus the current waddr and wdata for exactly 1 cycle, then go to IDLE.
REQ-027 EXEC with op 01: drive rf_op_code 01 plus the current raddr for exactly 1 cycle, then go to CAPT.
REQ-028 CAPT SHALL latch rf_read_data into rsp_data, set rsp_valid, and go to RSP; read issue to rsp_valid is 2 cycles.
REQ-029 RSP SHALL hold rsp_valid and rsp_data stable until rsp_ready; on the rsp_ready cycle it clears rsp_valid and goes to IDLE.
REQ-030 EXEC with op 10/11: drive that op for exactly ALU_LAT consecutive cycles (4-bit counter), then go to IDLE.
REQ-031 Instructions SHALL be issued strictly in order, with at most one in flight; a write followed by a read of the same register returns the written data.
REQ-032 rsp_ready asserted while rsp_valid is 0 SHALL be ignored.
REQ-033 Push and pop in the same cycle SHALL leave the occupancy count unchanged; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-034 With rst high at a clock edge: queue empty, pointers 0, FSM IDLE, counter 0, rsp_valid 0, rsp_data 0, and rf_* outputs per REQ-025.
REQ-035 Reset mid-operation SHALL abort the in-flight instruction, discard all queued entries and drop any pending response; no partial ALU hold continues.
REQ-036 While rst is high, instr_ready SHALL be 0.

Verification
REQ-037 Write then read: push {00, waddr 2, data 0x5A} then {01, raddr 2} -> one cycle of rf_op_code 00/addr 2, then 01/addr 2; rsp_valid rises 2 cycles after the read issue with rsp_data 0x5A.
REQ-038 ALU hold: ALU_LAT=3, push op 10 -> rf_op_code 10 for exactly 3 cycles, then 01; busy falls the cycle after.
REQ-039 Full queue: rsp_ready=0, push read, then 5 more -> instr_ready low once 4 are queued; the 6th is accepted only after the first response drains.
REQ-040 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable; no further issue; pops resume after the rsp_ready handshake.
REQ-041 Reset mid-ALU: assert rst on the 2nd hold cycle with 3 entries queued -> next cycle rf_op_code 01, busy 0, queue empty, rsp_valid 0.
REQ-042 Simultaneous push/pop with 2 entries queued -> occupancy stays 2; order preserved across pointer wrap.

Source files
------------

// File: rtl/vec_op_sequencer_if.sv
// Instruction, register-file and response signals of the vector op sequencer.
// The master side is the environment (upstream, register file, response sink).
interface vec_op_sequencer_if #(
  parameter int DATA_W = 512
);
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        instr_op;
  logic [1:0]        instr_raddr;
  logic [1:0]        instr_waddr;
  logic [DATA_W-1:0] instr_wdata;
  logic [1:0]        rf_op_code;
  logic [1:0]        rf_read_addr;
  logic [1:0]        rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_read_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready;
  logic              busy;

  modport master (
    output instr_valid, instr_op, instr_raddr, instr_waddr, instr_wdata,
    output rf_read_data, rsp_ready,
    input  instr_ready, rf_op_code, rf_read_addr, rf_write_addr, rf_write_data,
    input  rsp_valid, rsp_data, busy
  );

  modport slave (
    input  instr_valid, instr_op, instr_raddr, instr_waddr, instr_wdata,
    input  rf_read_data, rsp_ready,
    output instr_ready, rf_op_code, rf_read_addr, rf_write_addr, rf_write_data,
    output rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/vec_op_sequencer.sv
// Queues vector instructions and issues them one at a time to a register file,
// holding ALU ops for ALU_LAT cycles and returning read data through a handshake.
module vec_op_sequencer #(
  parameter int ALU_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 512
) (
  input logic               clk,
  input logic               rst,
  vec_op_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;

  typedef struct packed {
    logic [1:0]        op;
    logic [1:0]        raddr;
    logic [1:0]        waddr;
    logic [DATA_W-1:0] wdata;
  } instr_t;

  instr_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [1:0]        state;
  logic [3:0]        alu_cnt;
  logic              alu_last;
  instr_t            cur;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  assign full            = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign empty           = (fifo_cnt == '0);
  assign bus.instr_ready = !full && !rst;
  assign push            = bus.instr_valid && bus.instr_ready;
  // Pop only from registered occupancy, so a fresh entry waits one cycle.
  assign pop             = (state == S_IDLE) && !empty;
  assign alu_last        = (alu_cnt == 4'(ALU_LAT - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: bus.instr_op, raddr: bus.instr_raddr,
                       waddr: bus.instr_waddr, wdata: bus.instr_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Current instruction is payload only; state decides whether it is driven.
  always_ff @(posedge clk) begin
    if (pop) cur <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      alu_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            alu_cnt <= '0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cur.op)
            OP_WRITE: state <= S_IDLE;
            OP_READ:  state <= S_CAPT;
            default: begin
              if (alu_last) state <= S_IDLE;
              else          alu_cnt <= alu_cnt + 4'd1;
            end
          endcase
        end
        S_CAPT: begin
          rsp_data_q  <= bus.rf_read_data;
          rsp_valid_q <= 1'b1;
          state       <= S_RSP;
        end
        default: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Outside EXEC the register file sees a harmless read of register 0.
  always_comb begin
    bus.rf_op_code    = OP_READ;
    bus.rf_read_addr  = '0;
    bus.rf_write_addr = '0;
    bus.rf_write_data = '0;
    if (state == S_EXEC) begin
      bus.rf_op_code = cur.op;
      case (cur.op)
        OP_WRITE: begin
          bus.rf_write_addr = cur.waddr;
          bus.rf_write_data = cur.wdata;
        end
        OP_READ: begin
          bus.rf_read_addr = cur.raddr;
        end
        default: begin
          bus.rf_read_addr  = cur.raddr;
          bus.rf_write_addr = cur.waddr;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Directed bench for vec_op_sequencer with a small registered register-file model.
module tb_vec_op_sequencer;
  logic clk;
  logic rst;
  logic rf_clr;
  int   n_chk;
  int   n_pass;
  int   n_fail;

  logic [511:0] regs [4];
  logic [511:0] got_rsp [8];
  int           n_rsp;
  int           bad;

  vec_op_sequencer_if bus ();

  vec_op_sequencer #(
    .ALU_LAT    (3),
    .FIFO_DEPTH (4),
    .DATA_W     (512)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (bus.rf_op_code == 2'b00) begin
      regs[bus.rf_write_addr] <= bus.rf_write_data;
    end
    bus.rf_read_data <= regs[bus.rf_read_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] raddr,
                      input logic [1:0] waddr, input logic [511:0] wdata);
    int waited;
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_raddr = raddr;
    bus.instr_waddr = waddr;
    bus.instr_wdata = wdata;
    waited = 0;
    while (!bus.instr_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!bus.instr_ready) check("push_timeout", 512'(bus.instr_ready), 512'(1));
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic collect(input int n);
    int cyc;
    n_rsp = 0;
    cyc   = 0;
    while (n_rsp < n && cyc < 100) begin
      if (bus.rsp_valid) begin
        got_rsp[n_rsp] = bus.rsp_data;
        n_rsp++;
      end
      step();
      cyc++;
    end
    check("rsp_count", 512'(n_rsp), 512'(n));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; rf_clr = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_raddr = '0;
    bus.instr_waddr = '0;
    bus.instr_wdata = '0;
    bus.rsp_ready   = 1'b0;
    step();
    step();
    check("rst_ready",     512'(bus.instr_ready),  512'(0));
    check("rst_op",        512'(bus.rf_op_code),   512'(1));
    check("rst_wdata",     bus.rf_write_data,      512'(0));
    check("rst_busy",      512'(bus.busy),         512'(0));
    check("rst_rsp_valid", 512'(bus.rsp_valid),    512'(0));
    check("rst_rsp_data",  bus.rsp_data,           512'(0));
    rst = 1'b0; rf_clr = 1'b0;
    step();
    check("ready_after_rst", 512'(bus.instr_ready), 512'(1));

    // write reg2 = 0x5A, then read it back
    push(2'b00, 2'd0, 2'd2, 512'h5A);
    check("nobypass_op",   512'(bus.rf_op_code), 512'(1));
    check("nobypass_cnt",  512'(dut.fifo_cnt),   512'(1));
    check("nobypass_busy", 512'(bus.busy),       512'(1));
    push(2'b01, 2'd2, 2'd0, 512'h0);
    check("wr_op",    512'(bus.rf_op_code),    512'(0));
    check("wr_addr",  512'(bus.rf_write_addr), 512'(2));
    check("wr_data",  bus.rf_write_data,       512'h5A);
    step();
    check("wr_done_op", 512'(bus.rf_op_code), 512'(1));
    step();
    check("rd_op",   512'(bus.rf_op_code),   512'(1));
    check("rd_addr", 512'(bus.rf_read_addr), 512'(2));
    step();
    check("rd_capt_valid", 512'(bus.rsp_valid), 512'(0));
    step();
    check("rd_rsp_valid", 512'(bus.rsp_valid), 512'(1));
    check("rd_rsp_data",  bus.rsp_data,        512'h5A);
    bus.rsp_ready = 1'b1;
    step();
    check("rd_rsp_clear", 512'(bus.rsp_valid), 512'(0));
    check("rd_idle_busy", 512'(bus.busy),      512'(0));

    // ALU hold for 3 cycles
    push(2'b10, 2'd0, 2'd0, 512'h0);
    step();
    check("alu_hold1", 512'(bus.rf_op_code), 512'(2));
    step();
    check("alu_hold2", 512'(bus.rf_op_code), 512'(2));
    step();
    check("alu_hold3", 512'(bus.rf_op_code), 512'(2));
    check("alu_busy",  512'(bus.busy),       512'(1));
    step();
    check("alu_end_op",   512'(bus.rf_op_code), 512'(1));
    check("alu_end_busy", 512'(bus.busy),       512'(0));
    check("alu_no_rsp",   512'(bus.rsp_valid),  512'(0));

    // full queue behind a stalled response, then backpressure
    bus.rsp_ready = 1'b0;
    push(2'b01, 2'd2, 2'd0, 512'h0);
    push(2'b00, 2'd0, 2'd1, 512'h11);
    push(2'b00, 2'd0, 2'd3, 512'h33);
    push(2'b01, 2'd1, 2'd0, 512'h0);
    push(2'b01, 2'd3, 2'd0, 512'h0);
    check("full_ready", 512'(bus.instr_ready), 512'(0));
    check("full_cnt",   512'(dut.fifo_cnt),    512'(4));
    bus.instr_valid = 1'b1;
    bus.instr_op    = 2'b01;
    bus.instr_raddr = 2'd2;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.instr_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
          bus.rsp_data !== 512'h5A || bus.rf_op_code !== 2'b01 ||
          dut.fifo_cnt !== 3'd4) bad++;
    end
    check("bp_stable_cycles", 512'(bad), 512'(0));
    check("bp_rsp_data", bus.rsp_data, 512'h5A);
    bus.rsp_ready = 1'b1;
    push(2'b01, 2'd2, 2'd0, 512'h0);
    collect(3);
    check("order_rsp0", got_rsp[0], 512'h11);
    check("order_rsp1", got_rsp[1], 512'h33);
    check("order_rsp2", got_rsp[2], 512'h5A);

    // reset on the second ALU hold cycle with 3 entries queued
    bus.rsp_ready = 1'b0;
    push(2'b01, 2'd0, 2'd0, 512'h0);
    push(2'b10, 2'd0, 2'd0, 512'h0);
    push(2'b00, 2'd0, 2'd0, 512'hEE);
    push(2'b01, 2'd1, 2'd0, 512'h0);
    push(2'b11, 2'd0, 2'd0, 512'h0);
    check("rstalu_full", 512'(dut.fifo_cnt), 512'(4));
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    step();
    check("rstalu_hold1", 512'(bus.rf_op_code), 512'(2));
    check("rstalu_cnt3",  512'(dut.fifo_cnt),   512'(3));
    step();
    check("rstalu_hold2", 512'(bus.rf_op_code), 512'(2));
    rst = 1'b1;
    #1;
    check("rstalu_ready_low", 512'(bus.instr_ready), 512'(0));
    step();
    check("rstalu_op",       512'(bus.rf_op_code), 512'(1));
    check("rstalu_busy",     512'(bus.busy),       512'(0));
    check("rstalu_empty",    512'(dut.fifo_cnt),   512'(0));
    check("rstalu_rsp",      512'(bus.rsp_valid),  512'(0));
    check("rstalu_rsp_data", bus.rsp_data,         512'(0));
    rst = 1'b0;
    step();
    check("postrst_op",    512'(bus.rf_op_code),  512'(1));
    check("postrst_busy",  512'(bus.busy),        512'(0));
    check("postrst_ready", 512'(bus.instr_ready), 512'(1));

    // simultaneous push/pop with 2 queued, across pointer wrap
    push(2'b01, 2'd2, 2'd0, 512'h0);
    push(2'b00, 2'd0, 2'd1, 512'hA1);
    push(2'b00, 2'd0, 2'd1, 512'hB2);
    step();
    check("sim_rsp_valid", 512'(bus.rsp_valid), 512'(1));
    check("sim_rsp_data",  bus.rsp_data,        512'h5A);
    check("sim_cnt_pre",   512'(dut.fifo_cnt),  512'(2));
    bus.rsp_ready = 1'b1;
    step();
    push(2'b00, 2'd0, 2'd3, 512'hC3);
    check("sim_cnt_same", 512'(dut.fifo_cnt), 512'(2));
    push(2'b01, 2'd1, 2'd0, 512'h0);
    push(2'b01, 2'd3, 2'd0, 512'h0);
    push(2'b01, 2'd0, 2'd0, 512'h0);
    collect(3);
    check("wrap_rsp0", got_rsp[0], 512'hB2);
    check("wrap_rsp1", got_rsp[1], 512'hC3);
    check("wrap_rsp2", got_rsp[2], 512'h0);
    step();
    step();
    check("final_busy", 512'(bus.busy), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
